// File: rtl/plot_queue.sv
// plot_queue: clips pixel-plot requests to the visible area and buffers them in a
// show-ahead FIFO that drains to the VGA framebuffer write port under valid/ready.
module plot_queue #(
   parameter int DEPTH = 8,
   parameter int X_MAX = 160,
   parameter int Y_MAX = 120
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 in_x,
   input  logic [7:0]                 in_y,
   input  logic [2:0]                 in_color,
   input  logic                       in_plot,
   output logic                       full,
   output logic [7:0]                 vga_x,
   output logic [6:0]                 vga_y,
   output logic [2:0]                 vga_color,
   output logic                       vga_plot,
   input  logic                       vga_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 drop_count,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [8:0] XM = 9'(X_MAX);
   localparam logic [8:0] YM = 9'(Y_MAX);

   logic [17:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    drop_q, drop_d;
   logic          ovf_q, ovf_d;
   logic          in_range, push, pop, drop;

   // full comes from the registered level, so a pop never frees a slot for a same-cycle push
   assign full      = level_q == LW'(DEPTH);
   assign vga_plot  = level_q != '0;
   assign in_range  = ({1'b0, in_x} < XM) && ({1'b0, in_y} < YM);
   assign push      = in_plot && in_range && !full;
   assign drop      = in_plot && !push;
   assign pop       = vga_plot && vga_ready;

   assign {vga_x, vga_y, vga_color} = mem_q[rd_ptr_q];
   assign level      = level_q;
   assign drop_count = drop_q;
   assign overflow   = ovf_q;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = (push && !pop) ? level_q + LW'(1) :
                 (pop && !push) ? level_q - LW'(1) : level_q;
      drop_d   = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
      ovf_d    = ovf_q || (in_plot && full);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         if (push) mem_q[wr_ptr_q] <= {in_x, in_y[6:0], in_color};
      end
   end
endmodule
